mant_mul_seq: RTL and testbench

MANT_MUL_SEQ -- requirements
Module: mant_mul_seq

---
 rtl/fma_pkg.sv | 44 ++++
 rtl/mant_lane_mac.sv | 42 ++++
 rtl/mant_mul_seq.sv | 183 ++++++++++++++++++
 tb/tb_mant_mul_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fma_pkg.sv
// Shared constants for the FMA mantissa datapath: mode codes, lane layout, digit size, FSM states.
package fma_pkg;

   localparam logic [1:0] MODE_HP = 2'b01;
   localparam logic [1:0] MODE_SP = 2'b10;
   localparam logic [1:0] MODE_DP = 2'b00;

   localparam int DIGIT_W = 8;
   localparam int CNT_W   = 3;

   // Operand lane widths and LSB positions within a/b
   localparam int HP_W    = 11;
   localparam int SP_W    = 24;
   localparam int DP_W    = 53;
   localparam int HP_OFF1 = 14;
   localparam int HP_OFF2 = 28;
   localparam int HP_OFF3 = 42;
   localparam int SP_OFF1 = 29;

   // Product lane widths and LSB positions within prod
   localparam int HP_PW    = 22;
   localparam int SP_PW    = 48;
   localparam int DP_PW    = 106;
   localparam int HP_POFF1 = 28;
   localparam int HP_POFF2 = 56;
   localparam int HP_POFF3 = 84;
   localparam int SP_POFF1 = 58;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mul_state_e;

   // Number of 8-bit b digits needed to cover one lane; 11 is treated as double.
   function automatic logic [CNT_W-1:0] iter_count(input logic [1:0] m);
      case (m)
         MODE_HP: iter_count = 3'd2;
         MODE_SP: iter_count = 3'd3;
         default: iter_count = 3'd7;
      endcase
   endfunction

endpackage

// File: rtl/mant_lane_mac.sv
// One multiplier lane: adds (multiplicand x b digit) << (8*shift_idx) into its accumulator.
// Accumulator updates on the edge after en; clr has priority and zeroes it.
module mant_lane_mac
   import fma_pkg::*;
#(
   parameter int A_W   = 53,
   parameter int ACC_W = 106
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               en,
   input  logic [A_W-1:0]     mcand,
   input  logic [DIGIT_W-1:0] digit,
   input  logic [CNT_W-1:0]   shift_idx,
   output logic [ACC_W-1:0]   acc
);

   logic [ACC_W-1:0] acc_d, acc_q;
   logic [ACC_W-1:0] pp;

   always_comb begin
      pp    = (ACC_W'(mcand) * ACC_W'(digit)) << (DIGIT_W * int'(shift_idx));
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q + pp;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/mant_mul_seq.sv
// Sequential lane-packed mantissa multiplier (1x53, 2x24, 4x11), one 8-bit b digit per cycle.
// Latency 7/3/2 cycles, or shorter when MANT_MUL_EARLY_EXIT_EN is defined; result held until out_ready.
module mant_mul_seq
   import fma_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [1:0]   mode,
   input  logic [52:0]  a,
   input  logic [52:0]  b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [105:0] prod,
   output logic [1:0]   out_mode
);

   mul_state_e         state_d, state_q;
   logic [CNT_W-1:0]   cnt_d, cnt_q;
   logic [1:0]         mode_d, mode_q;
   logic [DP_W-1:0]    a0_d, a0_q, b0_d, b0_q;
   logic [SP_W-1:0]    a1_d, a1_q, b1_d, b1_q;
   logic [HP_W-1:0]    a2_d, a2_q, b2_d, b2_q;
   logic [HP_W-1:0]    a3_d, a3_q, b3_d, b3_q;
   logic               lane_clr, lane_en;
   logic [CNT_W-1:0]   last_iter;
   logic [DP_PW-1:0]   acc0;
   logic [SP_PW-1:0]   acc1;
   logic [HP_PW-1:0]   acc2, acc3;

   assign last_iter = iter_count(mode_q) - 3'd1;

`ifdef MANT_MUL_EARLY_EXIT_EN
   logic rest_zero;
   // Digits still to come sit above the current low digit of each shifting b register.
   assign rest_zero = (b0_q[DP_W-1:DIGIT_W] == '0) && (b1_q[SP_W-1:DIGIT_W] == '0) &&
                      (b2_q[HP_W-1:DIGIT_W] == '0) && (b3_q[HP_W-1:DIGIT_W] == '0);
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mode_d   = mode_q;
      a0_d     = a0_q;
      a1_d     = a1_q;
      a2_d     = a2_q;
      a3_d     = a3_q;
      b0_d     = b0_q;
      b1_d     = b1_q;
      b2_d     = b2_q;
      b3_d     = b3_q;
      lane_clr = 1'b0;
      lane_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               state_d  = ST_BUSY;
               cnt_d    = '0;
               mode_d   = mode;
               lane_clr = 1'b1;
               a0_d = '0; a1_d = '0; a2_d = '0; a3_d = '0;
               b0_d = '0; b1_d = '0; b2_d = '0; b3_d = '0;
               case (mode)
                  MODE_HP: begin
                     a0_d = DP_W'(a[HP_W-1:0]);
                     b0_d = DP_W'(b[HP_W-1:0]);
                     a1_d = SP_W'(a[HP_OFF1 +: HP_W]);
                     b1_d = SP_W'(b[HP_OFF1 +: HP_W]);
                     a2_d = a[HP_OFF2 +: HP_W];
                     b2_d = b[HP_OFF2 +: HP_W];
                     a3_d = a[HP_OFF3 +: HP_W];
                     b3_d = b[HP_OFF3 +: HP_W];
                  end
                  MODE_SP: begin
                     a0_d = DP_W'(a[SP_W-1:0]);
                     b0_d = DP_W'(b[SP_W-1:0]);
                     a1_d = a[SP_OFF1 +: SP_W];
                     b1_d = b[SP_OFF1 +: SP_W];
                  end
                  default: begin
                     a0_d = a;
                     b0_d = b;
                  end
               endcase
            end
         end
         ST_BUSY: begin
            lane_en = 1'b1;
            cnt_d   = cnt_q + 3'd1;
            b0_d    = b0_q >> DIGIT_W;
            b1_d    = b1_q >> DIGIT_W;
            b2_d    = b2_q >> DIGIT_W;
            b3_d    = b3_q >> DIGIT_W;
            if (cnt_q == last_iter) begin
               state_d = ST_DONE;
            end
`ifdef MANT_MUL_EARLY_EXIT_EN
            if (rest_zero) begin
               state_d = ST_DONE;
            end
`endif
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         mode_q  <= 2'b00;
         a0_q    <= '0;
         a1_q    <= '0;
         a2_q    <= '0;
         a3_q    <= '0;
         b0_q    <= '0;
         b1_q    <= '0;
         b2_q    <= '0;
         b3_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         a0_q    <= a0_d;
         a1_q    <= a1_d;
         a2_q    <= a2_d;
         a3_q    <= a3_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
         b2_q    <= b2_d;
         b3_q    <= b3_d;
      end
   end

   mant_lane_mac #(.A_W(DP_W), .ACC_W(DP_PW)) u_lane0 (
      .clk(clk), .rst_n(rst_n), .clr(lane_clr), .en(lane_en),
      .mcand(a0_q), .digit(b0_q[DIGIT_W-1:0]), .shift_idx(cnt_q), .acc(acc0)
   );

   mant_lane_mac #(.A_W(SP_W), .ACC_W(SP_PW)) u_lane1 (
      .clk(clk), .rst_n(rst_n), .clr(lane_clr), .en(lane_en),
      .mcand(a1_q), .digit(b1_q[DIGIT_W-1:0]), .shift_idx(cnt_q), .acc(acc1)
   );

   mant_lane_mac #(.A_W(HP_W), .ACC_W(HP_PW)) u_lane2 (
      .clk(clk), .rst_n(rst_n), .clr(lane_clr), .en(lane_en),
      .mcand(a2_q), .digit(b2_q[DIGIT_W-1:0]), .shift_idx(cnt_q), .acc(acc2)
   );

   mant_lane_mac #(.A_W(HP_W), .ACC_W(HP_PW)) u_lane3 (
      .clk(clk), .rst_n(rst_n), .clr(lane_clr), .en(lane_en),
      .mcand(a3_q), .digit(b3_q[DIGIT_W-1:0]), .shift_idx(cnt_q), .acc(acc3)
   );

   // Gap bits between lane fields are forced to zero rather than taken from the accumulators.
   always_comb begin
      prod = '0;
      case (mode_q)
         MODE_HP: begin
            prod[HP_PW-1:0]          = acc0[HP_PW-1:0];
            prod[HP_POFF1 +: HP_PW]  = acc1[HP_PW-1:0];
            prod[HP_POFF2 +: HP_PW]  = acc2;
            prod[HP_POFF3 +: HP_PW]  = acc3;
         end
         MODE_SP: begin
            prod[SP_PW-1:0]          = acc0[SP_PW-1:0];
            prod[SP_POFF1 +: SP_PW]  = acc1;
         end
         default: prod = acc0;
      endcase
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign out_mode  = mode_q;

endmodule

// File: tb/tb_mant_mul_seq.sv
// Directed vector bench for mant_mul_seq: table of lane-packed products plus backpressure and mid-op reset sequences.
module tb_mant_mul_seq;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   mode;
   logic [52:0]  a;
   logic [52:0]  b;
   logic         out_valid;
   logic         out_ready;
   logic [105:0] prod;
   logic [1:0]   out_mode;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic [1:0]   mode;
      logic [52:0]  a;
      logic [52:0]  b;
      logic [105:0] exp_prod;
      int           lat;
      int           lat_ee;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs[NV];

   always #5 clk = ~clk;

   mant_mul_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .prod(prod), .out_mode(out_mode)
   );

   function automatic logic [52:0] hp_op(input logic [10:0] l0, l1, l2, l3);
      logic [52:0] r;
      r = '0;
      r[10:0] = l0; r[24:14] = l1; r[38:28] = l2; r[52:42] = l3;
      return r;
   endfunction

   function automatic logic [52:0] sp_op(input logic [23:0] l0, l1);
      logic [52:0] r;
      r = '0;
      r[23:0] = l0; r[52:29] = l1;
      return r;
   endfunction

   function automatic logic [105:0] hp_prod(input logic [21:0] p0, p1, p2, p3);
      logic [105:0] r;
      r = '0;
      r[21:0] = p0; r[49:28] = p1; r[77:56] = p2; r[105:84] = p3;
      return r;
   endfunction

   function automatic logic [105:0] sp_prod(input logic [47:0] p0, p1);
      logic [105:0] r;
      r = '0;
      r[47:0] = p0; r[105:58] = p1;
      return r;
   endfunction

   task automatic check(input string name, input logic [105:0] act, input logic [105:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   // Presents one operation, returns cycles from the accepting edge to out_valid.
   task automatic run_op(input vec_t v, input bit hs, output int lat,
                         output logic [105:0] p, output logic [1:0] om);
      mode = v.mode; a = v.a; b = v.b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      p  = prod;
      om = out_mode;
      if (hs) begin
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
   endtask

   function automatic int exp_lat(input vec_t v);
`ifdef MANT_MUL_EARLY_EXIT_EN
      return v.lat_ee;
`else
      return v.lat;
`endif
   endfunction

   initial begin
      int           lat;
      logic [105:0] p;
      logic [1:0]   om;
      logic [105:0] held;

      vecs[0] = '{2'b00, 53'h10_0000_0000_0000, 53'h10_0000_0000_0000,
                  {2'b01, 104'h0}, 7, 7};
      vecs[1] = '{2'b01, hp_op(11'h400, 11'h400, 11'h400, 11'h400),
                  hp_op(11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF),
                  hp_prod(22'h1FFC00, 22'h1FFC00, 22'h1FFC00, 22'h1FFC00), 2, 2};
      vecs[2] = '{2'b10, sp_op(24'hFFFFFF, 24'h800000), sp_op(24'hFFFFFF, 24'h0),
                  sp_prod(48'hFFFFFE000001, 48'h0), 3, 3};
      vecs[3] = '{2'b00, 53'h1, 53'h1, 106'h1, 7, 1};
      vecs[4] = '{2'b00, 53'h1F_FFFF_FFFF_FFFF, 53'h1F_FFFF_FFFF_FFFF,
                  {52'hF_FFFF_FFFF_FFFF, 54'h1}, 7, 7};
      vecs[5] = '{2'b10, sp_op(24'h3, 24'h123456), sp_op(24'h5, 24'h10),
                  sp_prod(48'hF, 48'h1234560), 3, 1};
      vecs[6] = '{2'b01, hp_op(11'h1, 11'h2, 11'h3, 11'h7FF),
                  hp_op(11'h7FF, 11'h3, 11'h100, 11'h7FF),
                  hp_prod(22'h7FF, 22'h6, 22'h300, 22'h3FF001), 2, 2};
      vecs[7] = '{2'b11, 53'h1234, 53'h100, 106'h123400, 7, 2};
      vecs[8] = '{2'b00, 53'h12345, 53'h1F, 106'h23455B, 7, 1};
      vecs[9] = '{2'b11, 53'h1234, 53'h0101_0101, 106'h12_4646_4634, 7, 4};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      mode = 2'b00; a = '0; b = '0;

      #2;
      check("reset in_ready", 106'(in_ready), 106'(1));
      check("reset out_valid", 106'(out_valid), 106'(0));
      check("reset prod", prod, 106'h0);
      check("reset out_mode", 106'(out_mode), 106'(0));
      #5 rst_n = 1'b1;

      // First op goes in on the first rising edge after reset release.
      for (int i = 0; i < NV; i++) begin
         run_op(vecs[i], 1'b1, lat, p, om);
         check($sformatf("v%0d prod", i), p, vecs[i].exp_prod);
         check($sformatf("v%0d out_mode", i), 106'(om), 106'(vecs[i].mode));
         check($sformatf("v%0d latency", i), 106'(lat), 106'(exp_lat(vecs[i])));
      end

      // Backpressure: hold DONE for 5 cycles while a competing in_valid is offered.
      run_op(vecs[1], 1'b0, lat, p, om);
      held = p;
      mode = 2'b00; a = vecs[4].a; b = vecs[4].b; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check($sformatf("bp%0d prod", i), prod, held);
         check($sformatf("bp%0d out_mode", i), 106'(out_mode), 106'(2'b01));
         check($sformatf("bp%0d in_ready", i), 106'(in_ready), 106'(0));
         check($sformatf("bp%0d out_valid", i), 106'(out_valid), 106'(1));
      end
      check("bp held value", held, vecs[1].exp_prod);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b0;
      check("bp after hs in_ready", 106'(in_ready), 106'(1));
      check("bp after hs out_valid", 106'(out_valid), 106'(0));
      run_op(vecs[8], 1'b1, lat, p, om);
      check("bp next prod", p, vecs[8].exp_prod);

      // Reset in the middle of the third double-mode iteration.
      mode = vecs[9].mode; a = vecs[9].a; b = vecs[9].b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      check("midrst busy in_ready", 106'(in_ready), 106'(0));
      rst_n = 1'b0;
      #1;
      check("midrst in_ready", 106'(in_ready), 106'(1));
      check("midrst out_valid", 106'(out_valid), 106'(0));
      check("midrst prod", prod, 106'h0);
      check("midrst out_mode", 106'(out_mode), 106'(0));
      #3 rst_n = 1'b1;
      run_op(vecs[9], 1'b1, lat, p, om);
      check("midrst next prod", p, vecs[9].exp_prod);
      check("midrst next latency", 106'(lat), 106'(exp_lat(vecs[9])));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
